// File: rtl/mul_arbiter_if.sv
// Bundle between the multiplier arbiter, its two requesters and the shared
// multiplier. The slave modport is the arbiter's view; master is the far side.
interface mul_arbiter_if #(
    parameter int WIDTH = 16
);
    logic               Req0;
    logic               Req1;
    logic [WIDTH-1:0]   A0;
    logic [WIDTH-1:0]   B0;
    logic [WIDTH-1:0]   A1;
    logic [WIDTH-1:0]   B1;
    logic               Done0;
    logic               Done1;
    logic [2*WIDTH-1:0] Result;
    logic               Busy;
    logic [WIDTH-1:0]   MulA;
    logic [WIDTH-1:0]   MulB;
    logic               MulSt;
    logic [2*WIDTH-1:0] MulProduto;

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1, MulProduto,
        output Done0, Done1, Result, Busy, MulA, MulB, MulSt
    );

    modport master (
        output Req0, Req1, A0, B0, A1, B1, MulProduto,
        input  Done0, Done1, Result, Busy, MulA, MulB, MulSt
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier between two requesters.
// Ports: Clk, Reset (async active-low), bus (mul_arbiter_if.slave: requests,
// operands, Done pulses, Result, Busy, multiplier operands/strobe/product).
module mul_arbiter #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 33
) (
    input  logic         Clk,
    input  logic         Reset,
    mul_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               grant_q, grant_d;
    logic [WIDTH-1:0]   mula_q, mula_d;
    logic [WIDTH-1:0]   mulb_q, mulb_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               pick;

    // Contested: the side that did not win last time; otherwise whoever asks.
    assign pick = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        mula_d   = mula_q;
        mulb_d   = mulb_q;
        result_d = result_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    grant_d = pick;
                    mula_d  = pick ? bus.A1 : bus.A0;
                    mulb_d  = pick ? bus.B1 : bus.B0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = CW'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = bus.MulProduto;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // Done is registered, so it pulses in the cycle after DONE.
                done0_d = ~grant_q;
                done1_d = grant_q;
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            mula_q   <= '0;
            mulb_q   <= '0;
            result_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            mula_q   <= mula_d;
            mulb_q   <= mulb_d;
            result_q <= result_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    assign bus.MulA   = mula_q;
    assign bus.MulB   = mulb_q;
    assign bus.MulSt  = (state_q == S_START);
    assign bus.Busy   = (state_q != S_IDLE);
    assign bus.Result = result_q;
    assign bus.Done0  = done0_q;
    assign bus.Done1  = done1_q;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width of the shared multiplier.
REQ-002 SHALL have parameter LATENCY, default 33, clock cycles from multiplier St to valid Produto.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous active-low reset: asserted when 0, clears all state immediately, independent of Clk.
REQ-005 SHALL have ports Req0, Req1  input  1 each  level requests from requester 0 and requester 1.
REQ-006 SHALL have ports A0, B0, A1, B1  input  WIDTH each  multiplicand and multiplier operands of each requester.
REQ-007 SHALL have ports Done0, Done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-008 SHALL have port Result  output  2*WIDTH  product of the most recent completed operation.
REQ-009 SHALL have port Busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have ports MulA, MulB  output  WIDTH each  operands driven to the multiplier's Multiplicando and Multiplicador inputs.
REQ-011 SHALL have port MulSt  output  1  start strobe to the multiplier.
REQ-012 SHALL have port MulProduto  input  2*WIDTH  product from the multiplier.

Function
REQ-013 SHALL implement an FSM with states IDLE, START, WAIT and DONE.
REQ-014 IDLE, no request: SHALL remain in IDLE.
REQ-015 IDLE, any Req high: SHALL grant one requester, latch its A/B into MulA/MulB, record the grant, go to START.
REQ-016 Arbitration SHALL be round-robin via a Last register: if both Req are high, grant the requester other than Last; if one is high, grant it.
REQ-017 START: MulSt SHALL be 1 for exactly this one cycle; the counter SHALL load LATENCY-1; go to WAIT.
REQ-018 WAIT: the counter SHALL decrement each cycle; at 0, Result SHALL capture MulProduto, go to DONE.
REQ-019 DONE: the granted Done output SHALL be 1 for exactly one cycle, Last SHALL update to the granted index, go to IDLE.
REQ-020 MulA/MulB SHALL stay constant from the latch in IDLE through DONE, regardless of changes on A0/B0/A1/B1.
REQ-021 Req sampled high at edge E SHALL yield a Done pulse in the cycle after edge E+LATENCY+2 when the arbiter is idle and uncontested.
REQ-022 Req deasserted after grant SHALL NOT abort the operation; Done SHALL still pulse and Result SHALL still update.
REQ-023 Req still high in the cycle after its Done SHALL be treated as a new request and subject to round-robin.
REQ-024 Requests arriving while Busy SHALL be held pending by the requester and arbitrated only in IDLE.
REQ-025 Done0 and Done1 SHALL never be high in the same cycle; MulSt SHALL never be high outside START.
REQ-026 Result SHALL hold its value until the next DONE capture.
REQ-027 Product width SHALL be exactly 2*WIDTH with no truncation or sign extension (unsigned).

Reset
REQ-028 Reset=0 SHALL force state IDLE, counter 0, Last=1, MulA=MulB=0, MulSt=0, Done0=Done1=0, Busy=0, Result=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no Done pulse; after release the first request SHALL follow REQ-021 timing.
REQ-030 With Last=1 out of reset, the first simultaneous request SHALL be granted to requester 0.

Verification (WIDTH=16, LATENCY=33, behavioural multiplier model)
REQ-031 Reset=0 for 3 cycles with random inputs -> every output 0 and Busy=0 throughout.
REQ-032 Req0=1, A0=3, B0=5 -> MulSt one cycle, MulA=3, MulB=5, Done0 pulse per REQ-021, Result=15, Done1 never asserted.
REQ-033 Req0=Req1=1 held after reset, A0=7, B0=9, A1=0xFFFF, B1=0xFFFF -> Done0 with Result=63, then Done1 with Result=0xFFFE0001, then Done0 again (alternation).
REQ-034 Req1=1, A1=100, B1=200, A1 changed to 0 during WAIT and Req1 dropped after grant -> MulA stays 100, Done1 still pulses, Result=20000.
REQ-035 Reset=0 pulsed 10 cycles into WAIT -> no Done pulse, Busy=0 immediately; next Req0 with A0=2, B0=2 -> Result=4 on schedule.
REQ-036 Zero operands A0=0, B0=0x1234 -> Result=0, Done0 pulse.
